// File: rtl/dmem_pkg.sv
// Shared types for the data memory responder: access-mode encodings, FSM states,
// byte-lane masks and the alignment/lane helpers used on both load and store paths.
package dmem_pkg;

    typedef enum logic [2:0] {
        MODE_BYTE   = 3'b000,
        MODE_HALF   = 3'b001,
        MODE_WORD   = 3'b010,
        MODE_BYTE_U = 3'b011,
        MODE_HALF_U = 3'b100
    } mem_mode_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BUSY,
        ST_DONE
    } state_e;

    typedef logic [3:0] lane_mask_t;

    function automatic logic is_misaligned(input logic [2:0] mode, input logic [1:0] lo);
        case (mode)
            MODE_HALF, MODE_HALF_U: return lo[0];
            MODE_WORD:              return lo != 2'b00;
            default:                return 1'b0;
        endcase
    endfunction

    // Undefined modes yield an empty mask so they never touch the array.
    function automatic lane_mask_t lane_mask(input logic [2:0] mode, input logic [1:0] lo);
        case (mode)
            MODE_BYTE, MODE_BYTE_U: return lane_mask_t'(4'b0001 << lo);
            MODE_HALF, MODE_HALF_U: return lo[1] ? 4'b1100 : 4'b0011;
            MODE_WORD:              return 4'b1111;
            default:                return 4'b0000;
        endcase
    endfunction

endpackage

// File: rtl/load_align.sv
// Load-path byte/half selection with sign or zero extension; undefined modes return zero.
module load_align
    import dmem_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  addr,
    input  logic [2:0]  mode,
    output logic [31:0] result
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = word[7:0];
        case (addr)
            2'd0: byte_sel = word[7:0];
            2'd1: byte_sel = word[15:8];
            2'd2: byte_sel = word[23:16];
            2'd3: byte_sel = word[31:24];
            default: byte_sel = word[7:0];
        endcase
        half_sel = addr[1] ? word[31:16] : word[15:0];
    end

    always_comb begin
        result = '0;
        case (mode)
            MODE_BYTE:   result = {{24{byte_sel[7]}}, byte_sel};
            MODE_BYTE_U: result = {24'h0, byte_sel};
            MODE_HALF:   result = {{16{half_sel[15]}}, half_sel};
            MODE_HALF_U: result = {16'h0, half_sel};
            MODE_WORD:   result = word;
            default:     result = '0;
        endcase
    end

endmodule

// File: rtl/data_mem_responder.sv
// Multi-cycle data memory slave: latches one load/store, stalls the core for the
// configured wait time, then presents the result for a single DONE cycle.
module data_mem_responder
    import dmem_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rd_en,
    input  logic        wr_en,
    input  logic [2:0]  mem_mode,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        stall,
    output logic        misaligned
);

    localparam int unsigned AW = $clog2(DEPTH_WORDS);
    localparam logic [3:0] WAIT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    state_e        state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;
    logic [AW+1:0] addr_q, addr_d;
    logic [31:0]   wdata_q, wdata_d;
    logic [2:0]    mode_q, mode_d;
    logic          store_q, store_d;
    logic          fault_q, fault_d;
    logic          stall_c;

    logic [31:0]   mem [DEPTH_WORDS];
    logic [31:0]   rd_word, aligned, wr_lanes;
    lane_mask_t    wr_mask;
    logic          commit;

    // Upper address bits are deliberately dropped so the address space wraps.
    logic [31-AW-2:0] unused_addr_hi;
    assign unused_addr_hi = addr[31:AW+2];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        mode_d  = mode_q;
        store_d = store_q;
        fault_d = fault_q;
        stall_c = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (rd_en || wr_en) begin
                    stall_c = 1'b1;
                    addr_d  = addr[AW+1:0];
                    wdata_d = wdata;
                    mode_d  = mem_mode;
                    store_d = wr_en;
                    fault_d = is_misaligned(mem_mode, addr[1:0]);
                    if (WAIT_CYCLES == 0 || fault_d) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_BUSY;
                        cnt_d   = WAIT_INIT;
                    end
                end
            end
            ST_BUSY: begin
                stall_c = 1'b1;
                if (cnt_q == 4'd0) state_d = ST_DONE;
                else               cnt_d   = cnt_q - 4'd1;
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            mode_q  <= '0;
            store_q <= 1'b0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            mode_q  <= mode_d;
            store_q <= store_d;
            fault_q <= fault_d;
        end
    end

    // Sub-word store data is replicated across lanes; the mask picks the live ones.
    always_comb begin
        case (mode_q)
            MODE_BYTE, MODE_BYTE_U: wr_lanes = {4{wdata_q[7:0]}};
            MODE_HALF, MODE_HALF_U: wr_lanes = {2{wdata_q[15:0]}};
            default:                wr_lanes = wdata_q;
        endcase
        wr_mask = lane_mask(mode_q, addr_q[1:0]);
        commit  = (state_q == ST_DONE) && store_q && !fault_q;
    end

    always_ff @(posedge clk) begin
        if (commit) begin
            for (int unsigned i = 0; i < 4; i++) begin
                if (wr_mask[i]) mem[addr_q[AW+1:2]][8*i +: 8] <= wr_lanes[8*i +: 8];
            end
        end
    end

    assign rd_word = mem[addr_q[AW+1:2]];

    load_align u_load_align (
        .word   (rd_word),
        .addr   (addr_q[1:0]),
        .mode   (mode_q),
        .result (aligned)
    );

    assign stall      = stall_c && !rst;
    assign misaligned = (state_q == ST_DONE) && fault_q;
    assign rdata      = ((state_q == ST_DONE) && !store_q && !fault_q) ? aligned : '0;

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: directed table, byte-array reference model under
// random traffic, and reset-abandon sequences.
module tb_data_mem_responder;

    localparam int unsigned DEPTH = 16;
    localparam int unsigned WAITC = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rd_en = 1'b0;
    logic        wr_en = 1'b0;
    logic [2:0]  mem_mode = '0;
    logic [31:0] addr = '0;
    logic [31:0] wdata = '0;
    logic [31:0] rdata;
    logic        stall;
    logic        misaligned;

    int errors = 0;
    int checks = 0;

    data_mem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(WAITC)) dut (
        .clk        (clk),
        .rst        (rst),
        .rd_en      (rd_en),
        .wr_en      (wr_en),
        .mem_mode   (mem_mode),
        .addr       (addr),
        .wdata      (wdata),
        .rdata      (rdata),
        .stall      (stall),
        .misaligned (misaligned)
    );

    always #5 clk = ~clk;

    logic [7:0] mm [4*DEPTH];

    typedef struct {
        logic        rd;
        logic        wr;
        logic [2:0]  mode;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          cyc;
        logic        mis;
        logic        chk_rd;
        logic [31:0] rdat;
    } vec_t;

    vec_t tbl [25];

    function automatic vec_t mk(input logic rd, input logic wr, input logic [2:0] m,
                                input logic [31:0] a, input logic [31:0] wd, input int cyc,
                                input logic mis, input logic chk, input logic [31:0] r);
        vec_t v;
        v.rd = rd; v.wr = wr; v.mode = m; v.addr = a; v.wdata = wd;
        v.cyc = cyc; v.mis = mis; v.chk_rd = chk; v.rdat = r;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h expected=%h", name, got, exp);
        end
    endtask

    // Reference: memory as a flat byte array, access size from mode, little-endian.
    task automatic model_access(input logic wr, input logic [2:0] m, input logic [31:0] a,
                                input logic [31:0] wd, output int e_cyc, output logic e_mis,
                                output logic [31:0] e_rd);
        int unsigned base, size;
        logic [31:0] val, tmp;
        logic fault;
        base = a % (4 * DEPTH);
        case (m)
            3'd0, 3'd3: size = 1;
            3'd1, 3'd4: size = 2;
            3'd2:       size = 4;
            default:    size = 0;
        endcase
        fault = (size != 0) && (base % size != 0);
        e_cyc = fault ? 1 : WAITC + 1;
        e_mis = fault;
        e_rd  = '0;
        if (size != 0 && !fault) begin
            if (wr) begin
                for (int unsigned k = 0; k < size; k++) begin
                    tmp = wd >> (8 * k);
                    mm[base + k] = tmp[7:0];
                end
            end else begin
                val = '0;
                for (int unsigned k = 0; k < size; k++) val = val | (32'(mm[base + k]) << (8 * k));
                if (m == 3'd0 && val[7])  val = val | 32'hFFFF_FF00;
                if (m == 3'd1 && val[15]) val = val | 32'hFFFF_0000;
                e_rd = val;
            end
        end
    endtask

    // Starts at IDLE just after a rising edge; returns at IDLE just after a rising edge.
    task automatic run_access(input logic rd, input logic wr, input logic [2:0] m,
                              input logic [31:0] a, input logic [31:0] wd, output int cyc,
                              output logic [31:0] r, output logic mis, output logic idle_ok);
        int n;
        rd_en = rd; wr_en = wr; mem_mode = m; addr = a; wdata = wd;
        #1;
        cyc = stall ? 1 : 0;
        r = '0; mis = 1'b0;
        @(posedge clk); #1;
        rd_en = 1'b0; wr_en = 1'b0;
        addr = $urandom; wdata = $urandom; mem_mode = 3'($urandom);
        n = 0;
        while (stall && n < 40) begin
            cyc++; n++;
            @(posedge clk); #1;
        end
        if (stall) begin
            checks++; errors++;
            $display("FAIL timeout stall still high after 40 cycles");
        end
        r = rdata; mis = misaligned;
        @(posedge clk); #1;
        idle_ok = (rdata == '0) && !misaligned && !stall;
    endtask

    task automatic do_checked(input string nm, input logic rd, input logic wr, input logic [2:0] m,
                              input logic [31:0] a, input logic [31:0] wd);
        int cyc, e_cyc;
        logic [31:0] r, e_rd;
        logic mis, e_mis, idle_ok;
        model_access(wr, m, a, wd, e_cyc, e_mis, e_rd);
        run_access(rd, wr, m, a, wd, cyc, r, mis, idle_ok);
        check({nm, ".stall_cycles"}, 32'(cyc), 32'(e_cyc));
        check({nm, ".misaligned"}, 32'(mis), 32'(e_mis));
        if (!wr) check({nm, ".rdata"}, r, e_rd);
        check({nm, ".idle_quiet"}, 32'(idle_ok), 32'd1);
    endtask

    task automatic reset_during(input string nm, input int extra_edges, input logic [31:0] a);
        rd_en = 1'b0; wr_en = 1'b1; mem_mode = 3'd2; addr = a; wdata = 32'h1234_5678;
        @(posedge clk); #1;
        wr_en = 1'b0;
        repeat (extra_edges) begin
            @(posedge clk); #1;
        end
        rst = 1'b1;
        #1;
        check({nm, ".stall_in_rst"}, 32'(stall), 32'd0);
        check({nm, ".rdata_in_rst"}, rdata, 32'd0);
        check({nm, ".mis_in_rst"}, 32'(misaligned), 32'd0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        do_checked({nm, ".reload"}, 1'b1, 1'b0, 3'd2, a, 32'h0);
    endtask

    initial begin
        int cyc;
        logic [31:0] r, ra, rw;
        logic mis, idle_ok;
        logic [2:0] rm;
        logic rr, rwr;

        tbl[0]  = mk(0, 1, 3'd2, 32'h10, 32'hDEAD_BEEF, 3, 0, 0, 32'h0);
        tbl[1]  = mk(1, 0, 3'd2, 32'h10, 32'h0,         3, 0, 1, 32'hDEAD_BEEF);
        tbl[2]  = mk(0, 1, 3'd0, 32'h13, 32'hFFFF_FF80, 3, 0, 0, 32'h0);
        tbl[3]  = mk(1, 0, 3'd0, 32'h13, 32'h0,         3, 0, 1, 32'hFFFF_FF80);
        tbl[4]  = mk(1, 0, 3'd3, 32'h13, 32'h0,         3, 0, 1, 32'h0000_0080);
        tbl[5]  = mk(1, 0, 3'd2, 32'h10, 32'h0,         3, 0, 1, 32'h80AD_BEEF);
        tbl[6]  = mk(0, 1, 3'd2, 32'h20, 32'hCAFE_F00D, 3, 0, 0, 32'h0);
        tbl[7]  = mk(0, 1, 3'd1, 32'h21, 32'h0000_1234, 1, 1, 0, 32'h0);
        tbl[8]  = mk(1, 0, 3'd2, 32'h22, 32'h0,         1, 1, 1, 32'h0);
        tbl[9]  = mk(1, 0, 3'd2, 32'h20, 32'h0,         3, 0, 1, 32'hCAFE_F00D);
        tbl[10] = mk(0, 1, 3'd2, 32'h00, 32'h1122_3344, 3, 0, 0, 32'h0);
        tbl[11] = mk(1, 0, 3'd2, 32'h40, 32'h0,         3, 0, 1, 32'h1122_3344);
        tbl[12] = mk(1, 1, 3'd2, 32'h08, 32'h55AA_55AA, 3, 0, 0, 32'h0);
        tbl[13] = mk(1, 0, 3'd2, 32'h08, 32'h0,         3, 0, 1, 32'h55AA_55AA);
        tbl[14] = mk(0, 1, 3'd2, 32'h28, 32'h0,         3, 0, 0, 32'h0);
        tbl[15] = mk(0, 1, 3'd4, 32'h2A, 32'h1234_8001, 3, 0, 0, 32'h0);
        tbl[16] = mk(1, 0, 3'd1, 32'h2A, 32'h0,         3, 0, 1, 32'hFFFF_8001);
        tbl[17] = mk(1, 0, 3'd4, 32'h2A, 32'h0,         3, 0, 1, 32'h0000_8001);
        tbl[18] = mk(1, 0, 3'd2, 32'h28, 32'h0,         3, 0, 1, 32'h8001_0000);
        tbl[19] = mk(1, 0, 3'd5, 32'h04, 32'h0,         3, 0, 1, 32'h0);
        tbl[20] = mk(0, 1, 3'd7, 32'h00, 32'hFFFF_FFFF, 3, 0, 0, 32'h0);
        tbl[21] = mk(1, 0, 3'd2, 32'h00, 32'h0,         3, 0, 1, 32'h1122_3344);
        tbl[22] = mk(1, 0, 3'd4, 32'h23, 32'h0,         1, 1, 1, 32'h0);
        tbl[23] = mk(1, 0, 3'd3, 32'h21, 32'h0,         3, 0, 1, 32'h0000_00F0);
        tbl[24] = mk(1, 0, 3'd2, 32'h50, 32'h0,         3, 0, 1, 32'h80AD_BEEF);

        // Reset state, including a request held high while reset is asserted.
        #3;
        check("reset.stall", 32'(stall), 32'd0);
        check("reset.rdata", rdata, 32'd0);
        check("reset.misaligned", 32'(misaligned), 32'd0);
        rd_en = 1'b1;
        #1;
        check("reset.stall_with_req", 32'(stall), 32'd0);
        rd_en = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;

        for (int unsigned w = 0; w < DEPTH; w++) do_checked("init", 1'b0, 1'b1, 3'd2, 32'(4 * w), $urandom);

        for (int i = 0; i < 25; i++) begin
            int e_cyc;
            logic e_mis;
            logic [31:0] e_rd;
            model_access(tbl[i].wr, tbl[i].mode, tbl[i].addr, tbl[i].wdata, e_cyc, e_mis, e_rd);
            run_access(tbl[i].rd, tbl[i].wr, tbl[i].mode, tbl[i].addr, tbl[i].wdata, cyc, r, mis, idle_ok);
            check($sformatf("tbl%0d.stall_cycles", i), 32'(cyc), 32'(tbl[i].cyc));
            check($sformatf("tbl%0d.misaligned", i), 32'(mis), 32'(tbl[i].mis));
            if (tbl[i].chk_rd) check($sformatf("tbl%0d.rdata", i), r, tbl[i].rdat);
            check($sformatf("tbl%0d.idle_quiet", i), 32'(idle_ok), 32'd1);
        end

        reset_during("rst_busy", 0, 32'h30);
        reset_during("rst_done", 2, 32'h34);

        for (int i = 0; i < 80; i++) begin
            rr  = 1'($urandom);
            rwr = 1'($urandom);
            if (!rr && !rwr) rr = 1'b1;
            rm = ($urandom_range(0, 9) > 7) ? 3'd2 : 3'($urandom_range(0, 7));
            ra = $urandom;
            if ($urandom_range(0, 1) == 1) ra = ra & 32'hFFFF_FFFC;
            rw = $urandom;
            do_checked($sformatf("rand%0d", i), rr, rwr, rm, ra, rw);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/data_mem_responder.md
DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 1024, number of 32-bit words stored (power of two).
REQ-002 SHALL have parameter WAIT_CYCLES, default 2, extra busy cycles per access (0..15).
REQ-003 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port rd_en  input  1  load request from controller.
REQ-006 SHALL have port wr_en  input  1  store request from controller.
REQ-007 SHALL have port mem_mode  input  3  000 byte, 001 half, 010 word, 011 byte unsigned, 100 half unsigned.
REQ-008 SHALL have port addr  input  32  byte address (ALU result).
REQ-009 SHALL have port wdata  input  32  store data; low byte/half used for sub-word stores.
REQ-010 SHALL have port rdata  output  32  extended load result, valid in DONE cycle.
REQ-011 SHALL have port stall  output  1  high while access incomplete; holds PC and regfile write.
REQ-012 SHALL have port misaligned  output  1  one-cycle pulse in DONE for an alignment fault.

Function
REQ-013 SHALL implement FSM IDLE, BUSY, DONE.
REQ-014 In IDLE, rd_en|wr_en SHALL be accepted: addr, wdata, mem_mode, and the access kind are latched; stall is asserted combinationally in that same cycle.
REQ-015 On acceptance: if WAIT_CYCLES=0 or the access is faulted, the next state SHALL be DONE; otherwise it SHALL be BUSY with the counter loaded to WAIT_CYCLES-1.
REQ-016 BUSY SHALL decrement the counter each cycle and go to DONE when the counter reaches 0; stall stays high throughout.
REQ-017 DONE SHALL last exactly one cycle with stall=0.
- Stores commit to the array on the clock edge that leaves DONE.
- rdata is driven from the latched address.
- Next state is IDLE; request inputs are ignored in DONE.
REQ-018 Stall SHALL be high for exactly WAIT_CYCLES+1 cycles per unfaulted access.
REQ-019 If rd_en and wr_en are both high, the access SHALL be treated as a store.
REQ-020 Word index SHALL be addr[log2(DEPTH_WORDS)+1:2]; upper address bits are ignored, so addresses wrap.
REQ-021 Store byte-lane enables SHALL be: byte modes, lane addr[1:0]; half modes, lanes {addr[1],0} and {addr[1],1}; word, all four. Unenabled bytes are unchanged.
REQ-022 Loads SHALL select the byte/half by addr[1:0]; modes 000/001 sign-extend, 011/100 zero-extend, 010 returns the full word.
REQ-023 Half access with addr[0]=1 or word access with addr[1:0]!=0 SHALL fault: no array write, rdata=0, misaligned=1 in DONE.
REQ-024 mem_mode 101-111 SHALL perform no access, return rdata=0 and misaligned=0, and use normal FSM timing.
REQ-025 Outside DONE, rdata SHALL be 0 and misaligned SHALL be 0.

Reset
REQ-026 rst SHALL force IDLE, counter 0, latched request cleared, stall=0, rdata=0, misaligned=0, immediately and independent of clk.
REQ-027 rst asserted during BUSY or DONE SHALL abandon the access; no array write occurs.
REQ-028 Array contents SHALL NOT be reset.

Structure
REQ-029 Shared package dmem_pkg SHALL hold the mem_mode encodings as an enum, the FSM state enum, and the byte-lane mask type.
REQ-030 Byte selection and sign/zero extension SHALL live in combinational sub-module load_align (inputs word, addr[1:0], mode; output 32-bit result).

Verification
REQ-031 Word store 0xDEADBEEF at 0x10, then word load 0x10, WAIT_CYCLES=2 -> stall high 3 cycles each access; rdata=0xDEADBEEF in DONE.
REQ-032 Byte store 0x80 at 0x13, then mode 000 load at 0x13 -> rdata=0xFFFFFF80; mode 011 load -> 0x00000080; bytes 0x10-0x12 unchanged.
REQ-033 Half store at 0x21, then word load at 0x22 -> each: stall 1 cycle, misaligned=1, rdata=0, memory unchanged.
REQ-034 Store 0x11223344 at 0x0, then load at 4*DEPTH_WORDS -> rdata=0x11223344 (wrap).
REQ-035 Store in flight, rst pulsed during BUSY -> stall=0 immediately; later load of that address returns the old contents.
REQ-036 rd_en and wr_en both high, word 0x55AA55AA at 0x8 -> store performed; later load returns 0x55AA55AA.
